// File: rtl/softex_fp_minmax_stream_ctrl_pkg.sv
// Shared types for the streaming min/max reduction controller: element formats,
// reduction mode and controller state encoding.
package softex_fp_minmax_stream_ctrl_pkg;

  typedef enum logic [2:0] {
    FP32    = 3'd0,
    FP64    = 3'd1,
    FP16    = 3'd2,
    FP8     = 3'd3,
    FP16ALT = 3'd4
  } fp_format_e;

  localparam fp_format_e FPFORMAT_IN = FP16;

  typedef enum logic {
    MAX = 1'b0,
    MIN = 1'b1
  } min_max_mode_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } minmax_ctrl_state_t;

  function automatic int unsigned fp_width(fp_format_e fmt);
    case (fmt)
      FP32:    return 32;
      FP64:    return 64;
      FP16:    return 16;
      FP8:     return 8;
      FP16ALT: return 16;
      default: return 16;
    endcase
  endfunction

endpackage

// File: rtl/softex_fp_minmax_stream_ctrl_rec.sv
// Combinational min/max reducer over N_INP strobed lanes; on equal values the
// lowest-index strobed lane wins, which the fold relies on to keep the accumulator.
module softex_fp_minmax_stream_ctrl_rec
  import softex_fp_minmax_stream_ctrl_pkg::*;
#(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned N_INP  = 8
) (
  input  min_max_mode_t             mode_i,
  input  logic [N_INP*DATA_W-1:0]   data_i,
  input  logic [N_INP-1:0]          strb_i,
  output logic [DATA_W-1:0]         res_o,
  output logic                      vld_o
);

  // Sign-magnitude to monotonic unsigned key, so FP ordering becomes integer ordering.
  function automatic logic [DATA_W-1:0] fp_key(logic [DATA_W-1:0] x);
    if (x[DATA_W-1]) begin
      return ~x;
    end
    return {1'b1, x[DATA_W-2:0]};
  endfunction

  function automatic logic fp_gt(logic [DATA_W-1:0] a, logic [DATA_W-1:0] b);
    return fp_key(a) > fp_key(b);
  endfunction

  function automatic logic better(min_max_mode_t mode, logic [DATA_W-1:0] cand,
                                  logic [DATA_W-1:0] best);
    if (mode == MAX) begin
      return fp_gt(cand, best);
    end
    return fp_gt(best, cand);
  endfunction

  logic [DATA_W-1:0] lane;
  logic [DATA_W-1:0] best;
  logic              best_vld;

  always_comb begin
    lane     = '0;
    best     = '0;
    best_vld = 1'b0;
    for (int i = 0; i < int'(N_INP); i++) begin
      lane = data_i[i*DATA_W +: DATA_W];
      if (strb_i[i] && (!best_vld || better(mode_i, lane, best))) begin
        best     = lane;
        best_vld = 1'b1;
      end
    end
  end

  assign res_o = best;
  assign vld_o = best_vld;

endmodule

// File: rtl/softex_fp_minmax_stream_ctrl.sv
// Multi-beat streaming min/max reduction: folds each strobed beat into a running
// accumulator and returns one scalar per vector over a valid/ready handshake.
module softex_fp_minmax_stream_ctrl
  import softex_fp_minmax_stream_ctrl_pkg::*;
#(
  parameter fp_format_e  FPFORMAT  = FPFORMAT_IN,
  parameter int unsigned N_INP     = 8,
  parameter int unsigned LEN_WIDTH = 16,
  localparam int unsigned WIDTH    = fp_width(FPFORMAT)
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     clear_i,
  input  logic                     start_i,
  input  logic [LEN_WIDTH-1:0]     len_i,
  input  min_max_mode_t            mode_i,
  output logic                     busy_o,
  input  logic                     in_valid_i,
  output logic                     in_ready_o,
  input  logic [N_INP*WIDTH-1:0]   in_data_i,
  input  logic [N_INP-1:0]         in_strb_i,
  output logic                     res_valid_o,
  input  logic                     res_ready_i,
  output logic [WIDTH-1:0]         res_o,
  output logic                     res_empty_o
);

  minmax_ctrl_state_t   state_q;
  logic [LEN_WIDTH-1:0] remaining_q;
  min_max_mode_t        mode_q;
  logic [WIDTH-1:0]     acc_q;
  logic                 acc_vld_q;

  logic [WIDTH-1:0]     beat_res;
  logic                 beat_vld;
  logic [WIDTH-1:0]     fold_res;
  logic                 fold_vld;
  logic                 in_hs;
  logic                 start_hs;

  assign in_hs    = (state_q == ACCUM) && in_valid_i;
  assign start_hs = (state_q == IDLE) && start_i;

  softex_fp_minmax_stream_ctrl_rec #(
    .DATA_W (WIDTH),
    .N_INP  (N_INP)
  ) u_beat_rec (
    .mode_i (mode_q),
    .data_i (in_data_i),
    .strb_i (in_strb_i),
    .res_o  (beat_res),
    .vld_o  (beat_vld)
  );

  // Accumulator sits on lane 0 so an equal beat result never displaces it.
  softex_fp_minmax_stream_ctrl_rec #(
    .DATA_W (WIDTH),
    .N_INP  (2)
  ) u_fold_rec (
    .mode_i (mode_q),
    .data_i ({beat_res, acc_q}),
    .strb_i ({beat_vld, acc_vld_q}),
    .res_o  (fold_res),
    .vld_o  (fold_vld)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      remaining_q <= '0;
      mode_q      <= MAX;
      acc_vld_q   <= 1'b0;
    end else if (clear_i) begin
      state_q     <= IDLE;
      remaining_q <= '0;
      acc_vld_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start_i) begin
            mode_q      <= mode_i;
            acc_vld_q   <= 1'b0;
            remaining_q <= len_i;
            state_q     <= (len_i == '0) ? DONE : ACCUM;
          end
        end
        ACCUM: begin
          if (in_hs) begin
            remaining_q <= remaining_q - 1'b1;
            acc_vld_q   <= fold_vld;
            if (remaining_q == LEN_WIDTH'(1)) begin
              state_q <= DONE;
            end
          end
        end
        DONE: begin
          if (res_ready_i) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Accumulator data path: cleared on abort or a new vector, loaded on every beat.
  always_ff @(posedge clk_i) begin
    if (clear_i || start_hs) begin
      acc_q <= '0;
    end else if (in_hs) begin
      acc_q <= fold_res;
    end
  end

  assign busy_o      = (state_q != IDLE);
  assign in_ready_o  = (state_q == ACCUM);
  assign res_valid_o = (state_q == DONE);
  assign res_o       = res_valid_o ? acc_q : '0;
  assign res_empty_o = res_valid_o & ~acc_vld_q;

endmodule

// File: doc/softex_fp_minmax_stream_ctrl.md
# softex_fp_minmax_stream_ctrl

Multi-beat streaming min/max reduction controller. It accepts a vector of `len` beats, each `N_INP` lanes wide with per-lane strobes, and reduces every beat through a combinational lane reducer. It folds each beat result into a running accumulator and returns one scalar result through a valid/ready handshake. It sits in the softex normalization path, ahead of the exponent/subtraction stage, and supplies the per-row maximum (or minimum).

## Interface
Parameters:
- `FPFORMAT`, default `FPFORMAT_IN`: element format; `WIDTH = fpnew_pkg::fp_width(FPFORMAT)`.
- `N_INP`, default 8: lanes per beat (≥1).
- `LEN_WIDTH`, default 16: width of the beat counter and `len_i`.

Ports:
- `clk_i`, in, 1: clock.
- `rst_i`, in, 1: reset; synchronous, active-high.
- `clear_i`, in, 1: synchronous abort to IDLE.
- `start_i`, in, 1: start command; sampled only in IDLE.
- `len_i`, in, `LEN_WIDTH`: number of beats in the vector.
- `mode_i`, in, `softex_pkg::min_max_mode_t`: MAX or MIN; latched on start.
- `busy_o`, out, 1: high whenever the state is not IDLE.
- `in_valid_i`, in, 1: beat valid.
- `in_ready_o`, out, 1: beat ready.
- `in_data_i`, in, `N_INP×WIDTH`: beat lanes.
- `in_strb_i`, in, `N_INP`: lane strobes.
- `res_valid_o`, out, 1: result valid.
- `res_ready_i`, in, 1: result ready.
- `res_o`, out, `WIDTH`: reduced value.
- `res_empty_o`, out, 1: no strobed lane was seen during the vector.

## Operation
- FSM states: IDLE, ACCUM, DONE.
- IDLE:
  - `start_i` with `len_i≠0`: latch `len_i` into `remaining`, latch `mode_i`, clear the accumulator (`acc_vld=0`, `acc=0`), go to ACCUM.
  - `start_i` with `len_i=0`: go directly to DONE with `acc=0` and `acc_vld=0`.
- ACCUM:
  - `in_ready_o=1`.
  - On each handshake, reduce the beat lanes, gated by `in_strb_i`, to `beat_res`/`beat_vld`.
  - Fold into the accumulator with a 2-input compare. If both are valid, the winner under the latched mode replaces `acc`, and ties keep `acc`. If only one is valid, take it. `acc_vld |= beat_vld`.
  - `remaining` decrements on each handshake. The handshake with `remaining==1` moves to DONE.
- DONE:
  - `res_valid_o=1`, `res_o=acc`, `res_empty_o=~acc_vld`.
  - All three are held stable until `res_ready_i`, then go to IDLE.
- Comparison semantics: `FP_GT`/`FP_LT` from `softex_macros.svh`.
- A beat with all strobes 0 still consumes one count and leaves the accumulator unchanged.
- `start_i` outside IDLE is ignored. `in_valid_i` outside ACCUM is not acknowledged.
- `clear_i`: the next state is IDLE from any state. Any pending result is dropped and the accumulator is cleared. `clear_i` beats `start_i` in the same cycle.
- `rst_i` has priority over `clear_i`.

## Timing
- Reset values: state IDLE, `busy_o=0`, `in_ready_o=0`, `res_valid_o=0`, `res_o=0`, `res_empty_o=0`, `remaining=0`.
- `in_ready_o` and `res_valid_o` are decoded from registered state only; there is no combinational path from `in_valid_i` or `res_ready_i`.
- Start to the first possible beat handshake: 1 cycle, because `start_i` in cycle t gives `in_ready_o` in cycle t+1.
- Throughput: 1 beat per cycle in ACCUM.
- Last beat handshake in cycle t gives `res_valid_o` in cycle t+1.
- Result handshake in cycle t puts the FSM in IDLE in cycle t+1. A new `start_i` is accepted in t+1, so the minimum gap between results is 2 cycles.
- Beat reduction plus fold is single-cycle combinational into the `acc` register.
- `len_i=2^LEN_WIDTH−1` must complete without counter wrap.

## Structure
- Add to `softex_pkg`: `minmax_ctrl_state_t` enum {IDLE, ACCUM, DONE}.
- Reuse the existing `min_max_mode_t`.
- Sub-module `softex_fp_minmax_rec`, instantiated twice:
  - with `N_INP` lanes for the beat reduction;
  - with 2 lanes for the accumulator fold, wired `a=acc`, `b=beat_res` and strobes `{beat_vld, acc_vld}`. The MAX/MIN select is arranged so that ties keep `acc`.
- Registers: state, `remaining`, latched mode, `acc`, `acc_vld`.

## Test plan
All scenarios use FP16 values with `N_INP=4`.
- MAX, `len=2`: beats {0x3C00,0x4000,0xC200,0x3800} then {0x3800,0x3C00,0x3C00,0x3C00}, all strobes 1 → `res_o=0x4000`, `res_empty_o=0`, valid 1 cycle after the 2nd handshake.
- MIN, same data → `res_o=0xC200`. Repeat with strobe 0 on lane 2 of beat 1 → `res_o=0x3800`.
- `len=3`, all strobes 0 on every beat → 3 handshakes accepted, `res_empty_o=1`, `res_o=0x0000`.
- `len=0` → `res_valid_o=1` the cycle after start, `res_empty_o=1`, and no beat is ever acknowledged.
- Back-pressure: hold `res_ready_i=0` for 5 cycles. `res_o` stays stable, `start_i` is ignored and `in_ready_o` stays 0. Releasing it returns the FSM to IDLE in the next cycle.
- Abort: `clear_i` after 1 of 4 beats, then a fresh MAX start with `len=1` and {0x3800,…} → result 0x3800, with no contamination from the aborted vector. `rst_i` asserted mid-ACCUM returns every output to its reset value in the next cycle.
